// File: rtl/game_sequencer.sv
// game_sequencer: game-phase controller for the player sprite's position engine.
// Phase flow is idle -> countdown -> run -> hit -> game over. All decisions are
// taken on i_frame strobes, and every output is registered, so outputs change
// on the clock after the strobe and hold for the rest of the frame.
module game_sequencer #(
   parameter int POS_DIGIT         = 16,
   parameter int SPEED_INIT        = 2,
   parameter int SPEED_MAX         = 8,
   parameter int SPEED_STEP_FRAMES = 600,
   parameter int COUNTDOWN_FRAMES  = 180,
   parameter int HIT_FRAMES        = 90,
   parameter int JUMP_HEIGHT       = 15,
   parameter int FLOOR_INIT        = 64
) (
   input  logic                 i_clk_pix,
   input  logic                 i_rst_n,
   input  logic                 i_frame,
   input  logic                 i_btn_start,
   input  logic                 i_btn_jump,
   input  logic                 i_collide,
   input  logic                 i_spr_jumping,
   output logic                 o_spr_rst_n,
   output logic [5:0]           o_ctrl,
   output logic [15:0]          o_speed,
   output logic [POS_DIGIT-1:0] o_jump_height,
   output logic [POS_DIGIT-1:0] o_floor,
   output logic [15:0]          o_score,
   output logic [2:0]           o_state,
   output logic                 o_run
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_RUN   = 3'd2,
      ST_HIT   = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Terminal counts: the counter runs 0..N-1, so a phase lasts exactly N frames.
   localparam logic [15:0] LP_CD_LAST    = 16'(COUNTDOWN_FRAMES - 1);
   localparam logic [15:0] LP_STEP_LAST  = 16'(SPEED_STEP_FRAMES - 1);
   localparam logic [15:0] LP_HIT_LAST   = 16'(HIT_FRAMES - 1);
   localparam logic [15:0] LP_SPEED_INIT = 16'(SPEED_INIT);
   localparam logic [15:0] LP_SPEED_MAX  = 16'(SPEED_MAX);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_speed;
   logic [15:0] r_score;
   logic        r_spr_rst_n;
   logic        r_ctrl_right;
   logic        r_jump_pend;
   logic        r_run;
   logic        r_start_q;
   logic        r_jump_q;

   logic        w_start_press;
   logic        w_jump_press;

   // Increment that sticks at a ceiling; used for both score and speed.
   function automatic logic [15:0] f_sat_inc(input logic [15:0] i_val,
                                             input logic [15:0] i_lim);
      return (i_val >= i_lim) ? i_lim : i_val + 16'd1;
   endfunction

   // Presses are rising edges against the previous frame's sample; only
   // meaningful on strobe cycles, which is where they are consumed.
   assign w_start_press = i_btn_start & ~r_start_q;
   assign w_jump_press  = i_btn_jump  & ~r_jump_q;

   // Phase FSM with registered outputs; the state only moves on strobes,
   // except for recovery from an illegal encoding.
   always_ff @(posedge i_clk_pix) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 16'd0;
         r_speed      <= 16'd0;
         r_score      <= 16'd0;
         r_spr_rst_n  <= 1'b0;
         r_ctrl_right <= 1'b0;
         r_jump_pend  <= 1'b0;
         r_run        <= 1'b0;
         r_start_q    <= 1'b0;
         r_jump_q     <= 1'b0;
      end else begin
         if (i_frame) begin
            r_start_q <= i_btn_start;
            r_jump_q  <= i_btn_jump;
         end
         case (r_state)
            ST_IDLE: begin
               if (i_frame && w_start_press) begin
                  r_state     <= ST_COUNT;
                  r_cnt       <= 16'd0;
                  r_score     <= 16'd0;
                  r_spr_rst_n <= 1'b1;
               end
            end
            ST_COUNT: begin
               if (i_frame) begin
                  if (r_cnt == LP_CD_LAST) begin
                     // Jump is never looked at here, so the first RUN frame is jump-free.
                     r_state      <= ST_RUN;
                     r_cnt        <= 16'd0;
                     r_speed      <= LP_SPEED_INIT;
                     r_ctrl_right <= 1'b1;
                     r_run        <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            ST_RUN: begin
               if (i_frame) begin
                  if (i_collide) begin
                     // Collision outranks a same-strobe jump and the score tick.
                     r_state      <= ST_HIT;
                     r_cnt        <= 16'd0;
                     r_speed      <= 16'd0;
                     r_ctrl_right <= 1'b0;
                     r_jump_pend  <= 1'b0;
                     r_run        <= 1'b0;
                  end else begin
                     r_score     <= f_sat_inc(r_score, 16'hFFFF);
                     // One-frame jump pulse; presses while airborne are dropped, not queued.
                     r_jump_pend <= w_jump_press & ~i_spr_jumping;
                     if (r_cnt == LP_STEP_LAST) begin
                        r_cnt   <= 16'd0;
                        r_speed <= f_sat_inc(r_speed, LP_SPEED_MAX);
                     end else begin
                        r_cnt <= r_cnt + 16'd1;
                     end
                  end
               end
            end
            ST_HIT: begin
               if (i_frame) begin
                  if (r_cnt == LP_HIT_LAST) begin
                     r_state <= ST_OVER;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end
            ST_OVER: begin
               // Score is left alone so the final result stays visible in IDLE.
               if (i_frame && w_start_press) begin
                  r_state     <= ST_IDLE;
                  r_spr_rst_n <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_cnt        <= 16'd0;
               r_speed      <= 16'd0;
               r_spr_rst_n  <= 1'b0;
               r_ctrl_right <= 1'b0;
               r_jump_pend  <= 1'b0;
               r_run        <= 1'b0;
            end
         endcase
      end
   end

   assign o_spr_rst_n   = r_spr_rst_n;
   assign o_ctrl        = {1'b0, r_jump_pend, 3'b000, r_ctrl_right};
   assign o_speed       = r_speed;
   assign o_score       = r_score;
   assign o_state       = r_state;
   assign o_run         = r_run;
   assign o_jump_height = POS_DIGIT'(JUMP_HEIGHT);
   assign o_floor       = POS_DIGIT'(FLOOR_INIT);

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: frame-level vector table driven through game_sequencer,
// expectations queued at each strobe and compared one clock later, then held
// against randomised between-strobe input activity.
module tb_game_sequencer;

   localparam int POS_DIGIT = 16;

   logic                 i_clk_pix = 1'b0;
   logic                 i_rst_n;
   logic                 i_frame;
   logic                 i_btn_start;
   logic                 i_btn_jump;
   logic                 i_collide;
   logic                 i_spr_jumping;
   logic                 o_spr_rst_n;
   logic [5:0]           o_ctrl;
   logic [15:0]          o_speed;
   logic [POS_DIGIT-1:0] o_jump_height;
   logic [POS_DIGIT-1:0] o_floor;
   logic [15:0]          o_score;
   logic [2:0]           o_state;
   logic                 o_run;

   game_sequencer #(
      .POS_DIGIT        (POS_DIGIT),
      .SPEED_INIT       (2),
      .SPEED_MAX        (4),
      .SPEED_STEP_FRAMES(3),
      .COUNTDOWN_FRAMES (4),
      .HIT_FRAMES       (2),
      .JUMP_HEIGHT      (15),
      .FLOOR_INIT       (64)
   ) dut (
      .i_clk_pix    (i_clk_pix),
      .i_rst_n      (i_rst_n),
      .i_frame      (i_frame),
      .i_btn_start  (i_btn_start),
      .i_btn_jump   (i_btn_jump),
      .i_collide    (i_collide),
      .i_spr_jumping(i_spr_jumping),
      .o_spr_rst_n  (o_spr_rst_n),
      .o_ctrl       (o_ctrl),
      .o_speed      (o_speed),
      .o_jump_height(o_jump_height),
      .o_floor      (o_floor),
      .o_score      (o_score),
      .o_state      (o_state),
      .o_run        (o_run)
   );

   always #5 i_clk_pix = ~i_clk_pix;

   typedef struct packed {
      logic [2:0]  state;
      logic        spr;
      logic [5:0]  ctrl;
      logic [15:0] speed;
      logic [15:0] score;
      logic        run;
   } exp_t;

   typedef struct packed {
      logic st;
      logic jp;
      logic co;
      logic ja;
      exp_t exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic vec_t mk(input logic st, input logic jp, input logic co, input logic ja,
                               input logic [2:0] state, input logic spr, input logic [5:0] ctrl,
                               input int speed, input int score, input logic run);
      vec_t v;
      v.st        = st;
      v.jp        = jp;
      v.co        = co;
      v.ja        = ja;
      v.exp.state = state;
      v.exp.spr   = spr;
      v.exp.ctrl  = ctrl;
      v.exp.speed = 16'(speed);
      v.exp.score = 16'(score);
      v.exp.run   = run;
      return v;
   endfunction

   function automatic exp_t sample();
      exp_t a;
      a.state = o_state;
      a.spr   = o_spr_rst_n;
      a.ctrl  = o_ctrl;
      a.speed = o_speed;
      a.score = o_score;
      a.run   = o_run;
      return a;
   endfunction

   task automatic chk(input string name, input exp_t e);
      exp_t a;
      a = sample();
      n_total++;
      if (a === e) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got state=%0d spr_rst_n=%0b ctrl=%b speed=%0d score=%0d run=%0b; want state=%0d spr_rst_n=%0b ctrl=%b speed=%0d score=%0d run=%0b",
                  name, a.state, a.spr, a.ctrl, a.speed, a.score, a.run,
                  e.state, e.spr, e.ctrl, e.speed, e.score, e.run);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, want);
   endtask

   task automatic pop_chk(input string name, output exp_t last);
      last = '0;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty, got state=%0d want an entry", name, o_state);
      end else begin
         last = sb.pop_front();
         chk(name, last);
      end
   endtask

   // Toggle inputs randomly without a strobe; outputs must not move.
   task automatic gap(input string name, input exp_t e);
      repeat (3) begin
         i_btn_start   = 1'($urandom_range(0, 1));
         i_btn_jump    = 1'($urandom_range(0, 1));
         i_collide     = 1'($urandom_range(0, 1));
         i_spr_jumping = 1'($urandom_range(0, 1));
         @(posedge i_clk_pix);
         #1;
      end
      chk(name, e);
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      exp_t e;
      i_btn_start   = v.st;
      i_btn_jump    = v.jp;
      i_collide     = v.co;
      i_spr_jumping = v.ja;
      i_frame       = 1'b1;
      sb.push_back(v.exp);
      @(posedge i_clk_pix);
      #1;
      i_frame = 1'b0;
      pop_chk($sformatf("frame%0d", idx), e);
      gap($sformatf("hold%0d", idx), e);
   endtask

   initial begin
      exp_t e;
      exp_t rst_exp;
      rst_exp       = '0;
      i_rst_n       = 1'b0;
      i_frame       = 1'b0;
      i_btn_start   = 1'b0;
      i_btn_jump    = 1'b0;
      i_collide     = 1'b0;
      i_spr_jumping = 1'b0;

      // Reset state
      sb.push_back(rst_exp);
      repeat (2) @(posedge i_clk_pix);
      #1;
      pop_chk("reset", e);
      chk16("jump_height", o_jump_height, 16'd15);
      chk16("floor", o_floor, 16'd64);
      i_rst_n = 1'b1;
      @(posedge i_clk_pix);
      #1;

      //              st jp co ja  state spr ctrl   spd sc  run
      vecs.push_back(mk(0, 0, 0, 0, 3'd0, 0, 6'h00, 0,  0,  0)); // 0 idle
      vecs.push_back(mk(0, 0, 0, 0, 3'd0, 0, 6'h00, 0,  0,  0)); // 1
      vecs.push_back(mk(0, 0, 0, 0, 3'd0, 0, 6'h00, 0,  0,  0)); // 2
      vecs.push_back(mk(1, 1, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 3 start+jump: start only
      vecs.push_back(mk(1, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 4 held start
      vecs.push_back(mk(0, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 5
      vecs.push_back(mk(0, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 6
      vecs.push_back(mk(0, 1, 0, 0, 3'd2, 1, 6'h01, 2,  0,  1)); // 7 expiry+jump: no jump
      vecs.push_back(mk(0, 1, 0, 0, 3'd2, 1, 6'h01, 2,  1,  1)); // 8 held jump
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 2,  2,  1)); // 9
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 3,  3,  1)); // 10 speed step
      vecs.push_back(mk(0, 1, 0, 0, 3'd2, 1, 6'h11, 3,  4,  1)); // 11 jump press
      vecs.push_back(mk(0, 1, 0, 0, 3'd2, 1, 6'h01, 3,  5,  1)); // 12 one frame only
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 4,  6,  1)); // 13 speed step
      vecs.push_back(mk(0, 1, 0, 1, 3'd2, 1, 6'h01, 4,  7,  1)); // 14 airborne: dropped
      vecs.push_back(mk(0, 0, 0, 1, 3'd2, 1, 6'h01, 4,  8,  1)); // 15
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 4,  9,  1)); // 16 not queued, speed capped
      vecs.push_back(mk(0, 1, 0, 0, 3'd2, 1, 6'h11, 4,  10, 1)); // 17 jump press
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 4,  11, 1)); // 18
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 4,  12, 1)); // 19
      vecs.push_back(mk(0, 1, 1, 0, 3'd3, 1, 6'h00, 0,  12, 0)); // 20 collide+jump: HIT
      vecs.push_back(mk(0, 0, 1, 0, 3'd3, 1, 6'h00, 0,  12, 0)); // 21
      vecs.push_back(mk(0, 0, 0, 0, 3'd4, 1, 6'h00, 0,  12, 0)); // 22 OVER
      vecs.push_back(mk(0, 0, 0, 0, 3'd4, 1, 6'h00, 0,  12, 0)); // 23
      vecs.push_back(mk(1, 0, 0, 0, 3'd0, 0, 6'h00, 0,  12, 0)); // 24 back to IDLE, score kept
      vecs.push_back(mk(0, 0, 0, 0, 3'd0, 0, 6'h00, 0,  12, 0)); // 25
      vecs.push_back(mk(1, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 26 restart clears score
      vecs.push_back(mk(0, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 27
      vecs.push_back(mk(0, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 28
      vecs.push_back(mk(0, 0, 0, 0, 3'd1, 1, 6'h00, 0,  0,  0)); // 29
      vecs.push_back(mk(0, 0, 0, 0, 3'd2, 1, 6'h01, 2,  0,  1)); // 30
      vecs.push_back(mk(1, 0, 0, 0, 3'd2, 1, 6'h01, 2,  1,  1)); // 31 start ignored in RUN
      vecs.push_back(mk(1, 0, 0, 0, 3'd2, 1, 6'h01, 2,  2,  1)); // 32 start held

      for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i], i);

      // Reset for one clock mid-RUN
      i_rst_n = 1'b0;
      sb.push_back(rst_exp);
      @(posedge i_clk_pix);
      #1;
      i_rst_n = 1'b1;
      pop_chk("midrun_reset", e);

      // Previous-sample registers were cleared, so a held start counts as a press
      run_frame(mk(1, 0, 0, 0, 3'd1, 1, 6'h00, 0, 0, 0), 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
